// File: rtl/fake_mario_pio_pkg.sv
// Shared constants for the fake_mario parallel-input ports.
//   - Avalon register offsets (2-bit address map)
//   - edge-type selectors for the synchroniser/edge-detector
package fake_mario_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/fake_mario_sync_edge.sv
// Two-flop synchroniser plus previous-sample flop and per-bit edge detector.
// Reusable by any input PIO (HPI interrupt, keys, switches).
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   in_port   asynchronous input bits
//   level     synchronised input (second synchroniser stage)
//   edge_det  one-cycle pulse per bit when the selected edge is seen on level
module fake_mario_sync_edge
  import fake_mario_pio_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  // Resetting every stage to the same value means no edge is reported after
  // reset while the input sits at RESET_VALUE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= {WIDTH{RESET_VALUE}};
      sync2 <= {WIDTH{RESET_VALUE}};
      prev  <= {WIDTH{RESET_VALUE}};
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign level = sync2;

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign edge_det = sync2 & ~prev;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_det = ~sync2 & prev;
    end else begin : g_any
      assign edge_det = sync2 ^ prev;
    end
  endgenerate

endmodule

// File: rtl/fake_mario_otg_hpi_int_in.sv
// Avalon-MM slave input port for the CY7C67200 HPI interrupt line(s).
// Samples in_port into the clk domain, latches selected edges in a sticky
// RW1C edge-capture register and raises a maskable, registered IRQ.
//
// Register map (combinational read, zero wait states):
//   0 data          RO    synchronised input level
//   1 reserved      reads 0
//   2 irq_mask      RW    WIDTH bits
//   3 edge_capture  RW1C  WIDTH bits
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata      Avalon-MM slave write side
//   readdata                read data, zero-extended above WIDTH
//   in_port                 asynchronous interrupt input(s)
//   irq                     level interrupt to the processor
//
// Bus protocol: a write is accepted on every clk edge where
// chipselect && !write_n; there is no backpressure. Reads are a pure function
// of address, have no side effects and ignore chipselect.
module fake_mario_otg_hpi_int_in
  import fake_mario_pio_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask_next;
  logic [WIDTH-1:0] edge_capture_next;
  logic [WIDTH-1:0] clear_mask;
  logic             wr_en;
  logic             unused_wdata;

  fake_mario_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .level    (level),
    .edge_det (edge_det)
  );

  assign wr_en = chipselect && !write_n;

  // Bits of writedata above WIDTH are don't-care.
  assign unused_wdata = ^writedata;

  always_comb begin
    irq_mask_next = irq_mask;
    clear_mask    = '0;
    if (wr_en && (address == ADDR_IRQMASK)) begin
      irq_mask_next = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGECAP)) begin
      clear_mask = writedata[WIDTH-1:0];
    end
  end

  // OR-ing the new edges in after the clear means an edge arriving in the
  // same cycle as its clearing write is kept, never lost.
  assign edge_capture_next = (edge_capture & ~clear_mask) | edge_det;

  // irq is computed from the next-state values so it tracks capture and
  // mask changes on the same edge and is driven straight from a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      irq_mask     <= irq_mask_next;
      edge_capture <= edge_capture_next;
      irq          <= |(edge_capture_next & irq_mask_next);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = level;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_capture;
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_fake_mario_otg_hpi_int_in.sv
// Bench for fake_mario_otg_hpi_int_in: two instances (WIDTH=1 rising edge,
// WIDTH=4 any edge) on a shared bus with separate chipselects.
module tb_fake_mario_otg_hpi_int_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs1;
  logic        cs4;
  logic        write_n;
  logic [31:0] writedata;
  logic        in1;
  logic [3:0]  in4;
  logic [31:0] rd1;
  logic [31:0] rd4;
  logic        irq1;
  logic        irq4;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fake_mario_otg_hpi_int_in #(.WIDTH(1), .EDGE_TYPE(0), .RESET_VALUE(1'b0)) u_dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (cs1),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in1),
    .readdata   (rd1),
    .irq        (irq1)
  );

  fake_mario_otg_hpi_int_in #(.WIDTH(4), .EDGE_TYPE(2), .RESET_VALUE(1'b0)) u_dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (cs4),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in4),
    .readdata   (rd4),
    .irq        (irq4)
  );

  // ---------------- reference model ----------------
  // hist[k] holds the input value sampled k+1 clock edges ago; the readable
  // level is two edges old and an edge is judged between two and three edges old.
  logic [3:0] hist1 [3];
  logic [3:0] hist4 [3];
  logic [3:0] mask1, mask4, cap1, cap4, clr1, clr4;
  logic       mirq1, mirq4;

  function automatic logic [3:0] edges_of(logic [3:0] cur, logic [3:0] old, int et);
    if (et == 0) return cur & ~old;
    if (et == 1) return ~cur & old;
    return cur ^ old;
  endfunction

  function automatic logic [31:0] model_read(logic [1:0] a, logic [3:0] lvl,
                                             logic [3:0] msk, logic [3:0] cap);
    case (a)
      2'd0:    return {28'h0, lvl};
      2'd2:    return {28'h0, msk};
      2'd3:    return {28'h0, cap};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        hist1[i] = 4'h0;
        hist4[i] = 4'h0;
      end
      mask1 = 4'h0; mask4 = 4'h0;
      cap1  = 4'h0; cap4  = 4'h0;
      mirq1 = 1'b0; mirq4 = 1'b0;
    end else begin
      clr1 = 4'h0;
      clr4 = 4'h0;
      if (cs1 && !write_n) begin
        if (address == 2'd2) mask1 = writedata[3:0] & 4'h1;
        if (address == 2'd3) clr1  = writedata[3:0] & 4'h1;
      end
      if (cs4 && !write_n) begin
        if (address == 2'd2) mask4 = writedata[3:0];
        if (address == 2'd3) clr4  = writedata[3:0];
      end
      cap1  = ((cap1 & ~clr1) | edges_of(hist1[1], hist1[2], 0)) & 4'h1;
      cap4  = (cap4 & ~clr4) | edges_of(hist4[1], hist4[2], 2);
      mirq1 = |(cap1 & mask1);
      mirq4 = |(cap4 & mask4);
      hist1[2] = hist1[1]; hist1[1] = hist1[0]; hist1[0] = {3'b000, in1};
      hist4[2] = hist4[1]; hist4[1] = hist4[0]; hist4[0] = in4;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every falling edge: both DUTs against the model.
  always @(negedge clk) begin
    check("model_rd1",  rd1, model_read(address, hist1[1], mask1, cap1));
    check("model_rd4",  rd4, model_read(address, hist4[1], mask4, cap4));
    check("model_irq1", {31'h0, irq1}, {31'h0, mirq1});
    check("model_irq4", {31'h0, irq4}, {31'h0, mirq4});
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit dut4, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    if (dut4) cs4 = 1'b1;
    else      cs1 = 1'b1;
    step();
    cs1     = 1'b0;
    cs4     = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic chk_rd1(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, rd1, exp);
  endtask

  task automatic chk_rd4(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, rd4, exp);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n   = 1'b0;
    address   = 2'd0;
    cs1       = 1'b0;
    cs4       = 1'b0;
    write_n   = 1'b1;
    writedata = 32'h0;
    in1       = 1'b0;
    in4       = 4'h0;
    repeat (3) step();

    // Reset state
    for (int a = 0; a < 4; a++) begin
      chk_rd1("rst_rd1", a[1:0], 32'h0);
      chk_rd4("rst_rd4", a[1:0], 32'h0);
    end
    check("rst_irq1", {31'h0, irq1}, 32'h0);
    reset_n = 1'b1;
    repeat (10) step();
    for (int a = 0; a < 4; a++) chk_rd1("post_rst_rd1", a[1:0], 32'h0);
    check("post_rst_irq1", {31'h0, irq1}, 32'h0);

    // Rising edge, mask 0: data after 2 edges, capture after 3
    in1 = 1'b1;
    step();
    chk_rd1("data_t1", 2'd0, 32'h0);
    step();
    chk_rd1("data_t2", 2'd0, 32'h1);
    chk_rd1("cap_t2", 2'd3, 32'h0);
    step();
    chk_rd1("cap_t3", 2'd3, 32'h1);
    check("irq_unmasked", {31'h0, irq1}, 32'h0);

    // Clear, falling edge ignored, then enable mask
    wr(1'b0, 2'd3, 32'h1);
    chk_rd1("cap_cleared", 2'd3, 32'h0);
    in1 = 1'b0;
    repeat (4) step();
    chk_rd1("cap_fall_ignored", 2'd3, 32'h0);
    wr(1'b0, 2'd2, 32'h1);
    chk_rd1("mask_rd", 2'd2, 32'h1);

    // Two-cycle pulse, masked in
    in1 = 1'b1;
    step();
    step();
    in1 = 1'b0;
    step();
    check("irq_pulse_t3", {31'h0, irq1}, 32'h1);
    step();
    check("irq_pulse_t4", {31'h0, irq1}, 32'h1);
    chk_rd1("cap_pulse", 2'd3, 32'h1);
    wr(1'b0, 2'd3, 32'h1);
    check("irq_after_clear", {31'h0, irq1}, 32'h0);
    chk_rd1("cap_after_clear", 2'd3, 32'h0);

    // Clear coincident with a newly detected edge
    in1 = 1'b1;
    repeat (3) step();
    check("irq_first_rise", {31'h0, irq1}, 32'h1);
    in1 = 1'b0;
    step();
    step();
    in1 = 1'b1;
    step();
    step();
    wr(1'b0, 2'd3, 32'h1);
    chk_rd1("cap_coincident", 2'd3, 32'h1);
    check("irq_coincident", {31'h0, irq1}, 32'h1);
    wr(1'b0, 2'd3, 32'h1);
    chk_rd1("cap_clear2", 2'd3, 32'h0);
    check("irq_clear2", {31'h0, irq1}, 32'h0);

    // WIDTH=4, any edge
    in4 = 4'hA;
    repeat (3) step();
    chk_rd4("cap4_A", 2'd3, 32'hA);
    chk_rd4("data4_A", 2'd0, 32'hA);
    in4 = 4'h3;
    repeat (3) step();
    chk_rd4("cap4_B", 2'd3, 32'hB);
    wr(1'b1, 2'd3, 32'h0);
    chk_rd4("cap4_w0", 2'd3, 32'hB);
    wr(1'b1, 2'd3, 32'h2);
    chk_rd4("cap4_9", 2'd3, 32'h9);
    check("irq4_nomask", {31'h0, irq4}, 32'h0);
    wr(1'b1, 2'd2, 32'hFFFF_FFF5);
    chk_rd4("mask4_5", 2'd2, 32'h5);
    check("irq4_mask_pending", {31'h0, irq4}, 32'h1);
    chk_rd4("cap4_unchanged", 2'd3, 32'h9);

    // Asynchronous reset mid-capture
    in1 = 1'b0;
    step();
    step();
    in1 = 1'b1;
    repeat (3) step();
    check("irq_before_rst", {31'h0, irq1}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("irq_async_rst", {31'h0, irq1}, 32'h0);
    chk_rd1("cap_async_rst", 2'd3, 32'h0);
    check("irq4_async_rst", {31'h0, irq4}, 32'h0);
    in1 = 1'b0;
    in4 = 4'h0;
    step();
    step();
    reset_n = 1'b1;
    repeat (3) step();
    chk_rd1("mask_after_rst", 2'd2, 32'h0);
    chk_rd1("cap_after_rst", 2'd3, 32'h0);
    chk_rd4("mask4_after_rst", 2'd2, 32'h0);
    chk_rd4("cap4_after_rst", 2'd3, 32'h0);
    check("irq_after_rst", {31'h0, irq1}, 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
